// File: rtl/memory_responder.sv
// Data-side memory responder: word-addressed RAM plus a memory-mapped I/O page
// (LED latch, synchronized switches, cycle counter/compare, sticky status).
module memory_responder #(
  parameter int          DEPTH_LOG2 = 8,
  parameter logic [15:0] MMIO_PAGE  = 16'hFFFF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] memory_address,
  input  logic [31:0] memory_write_value,
  input  logic        memory_write_enable,
  output logic [31:0] memory_read_value,
  input  logic [17:0] SW,
  output logic [17:0] LEDR,
  output logic        timer_irq,
  output logic        bus_error
);

  localparam int          DEPTH       = 1 << DEPTH_LOG2;
  localparam logic [15:0] OFS_LED     = 16'h0000;
  localparam logic [15:0] OFS_SWITCH  = 16'h0004;
  localparam logic [15:0] OFS_CYCLE   = 16'h0008;
  localparam logic [15:0] OFS_COMPARE = 16'h000C;
  localparam logic [15:0] OFS_STATUS  = 16'h0010;

  logic [31:0] ram_r [0:DEPTH-1];
  logic [DEPTH_LOG2-1:0] ram_index_s;

  logic        misaligned_s;
  logic        io_sel_s;
  logic        ram_sel_s;
  logic        led_hit_s;
  logic        switch_hit_s;
  logic        cycle_hit_s;
  logic        compare_hit_s;
  logic        status_hit_s;
  logic        io_defined_s;
  logic        store_error_s;
  logic        ram_we_s;
  logic        led_we_s;
  logic        cycle_we_s;
  logic        compare_we_s;
  logic        status_we_s;

  logic [17:0] led_r;
  logic [17:0] sw_meta_r;
  logic [17:0] sw_sync_r;
  logic [31:0] cycle_r;
  logic [31:0] compare_r;
  logic [1:0]  status_r;

  logic [31:0] cycle_next_s;
  logic [1:0]  status_set_s;
  logic [1:0]  status_clr_s;
  logic [1:0]  status_next_s;
  logic [31:0] read_value_s;

  assign ram_index_s = memory_address[DEPTH_LOG2+1:2];

  // Region decode in priority order: misaligned, I/O page, RAM, unmapped.
  always_comb begin
    misaligned_s = (memory_address[1:0] != 2'b00);
    io_sel_s     = 1'b0;
    ram_sel_s    = 1'b0;
    if (misaligned_s) begin
      io_sel_s  = 1'b0;
      ram_sel_s = 1'b0;
    end else if (memory_address[31:16] == MMIO_PAGE) begin
      io_sel_s  = 1'b1;
    end else if ((memory_address >> (DEPTH_LOG2 + 2)) == 32'd0) begin
      ram_sel_s = 1'b1;
    end else begin
      io_sel_s  = 1'b0;
      ram_sel_s = 1'b0;
    end
  end

  // I/O register select within the page; unknown offsets hit nothing.
  always_comb begin
    led_hit_s     = 1'b0;
    switch_hit_s  = 1'b0;
    cycle_hit_s   = 1'b0;
    compare_hit_s = 1'b0;
    status_hit_s  = 1'b0;
    if (io_sel_s) begin
      case (memory_address[15:0])
        OFS_LED:     led_hit_s     = 1'b1;
        OFS_SWITCH:  switch_hit_s  = 1'b1;
        OFS_CYCLE:   cycle_hit_s   = 1'b1;
        OFS_COMPARE: compare_hit_s = 1'b1;
        OFS_STATUS:  status_hit_s  = 1'b1;
        default:     led_hit_s     = 1'b0;
      endcase
    end else begin
      led_hit_s = 1'b0;
    end
  end

  // Store qualification: illegal stores are dropped whole and only flag an error.
  always_comb begin
    io_defined_s  = led_hit_s | switch_hit_s | cycle_hit_s | compare_hit_s | status_hit_s;
    store_error_s = memory_write_enable & ~(ram_sel_s | io_defined_s);
    ram_we_s      = memory_write_enable & ram_sel_s;
    led_we_s      = memory_write_enable & led_hit_s;
    cycle_we_s    = memory_write_enable & cycle_hit_s;
    compare_we_s  = memory_write_enable & compare_hit_s;
    status_we_s   = memory_write_enable & status_hit_s;
  end

  // Combinational load path; reads never touch state.
  always_comb begin
    read_value_s = 32'd0;
    if (ram_sel_s) begin
      read_value_s = ram_r[ram_index_s];
    end else if (led_hit_s) begin
      read_value_s = {14'd0, led_r};
    end else if (switch_hit_s) begin
      read_value_s = {14'd0, sw_sync_r};
    end else if (cycle_hit_s) begin
      read_value_s = cycle_r;
    end else if (compare_hit_s) begin
      read_value_s = compare_r;
    end else if (status_hit_s) begin
      read_value_s = {30'd0, status_r};
    end else begin
      read_value_s = 32'd0;
    end
  end

  assign memory_read_value = read_value_s;

  // Counter and sticky status next state; a new set beats a same-edge W1C.
  always_comb begin
    cycle_next_s  = cycle_r + 32'd1;
    status_clr_s  = 2'b00;
    status_set_s  = {store_error_s, (cycle_r == compare_r)};
    if (cycle_we_s) begin
      cycle_next_s = memory_write_value;
    end else begin
      cycle_next_s = cycle_r + 32'd1;
    end
    if (status_we_s) begin
      status_clr_s = memory_write_value[1:0];
    end else begin
      status_clr_s = 2'b00;
    end
    status_next_s = status_set_s | (status_r & ~status_clr_s);
  end

  // I/O page registers and switch synchronizer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      led_r     <= 18'd0;
      sw_meta_r <= 18'd0;
      sw_sync_r <= 18'd0;
      cycle_r   <= 32'd0;
      compare_r <= 32'hFFFF_FFFF;
      status_r  <= 2'b00;
    end else begin
      sw_meta_r <= SW;
      sw_sync_r <= sw_meta_r;
      cycle_r   <= cycle_next_s;
      status_r  <= status_next_s;
      if (led_we_s) begin
        led_r <= memory_write_value[17:0];
      end
      if (compare_we_s) begin
        compare_r <= memory_write_value;
      end
    end
  end

  // RAM write port: contents survive reset, but no store lands while reset is held.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
    end else if (ram_we_s) begin
      ram_r[ram_index_s] <= memory_write_value;
    end
  end

  assign LEDR      = led_r;
  assign timer_irq = status_r[0];
  assign bus_error = status_r[1];

endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench for memory_responder: directed scenarios plus random traffic
// compared against a behavioural memory-map model.
module tb_memory_responder;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] memory_address;
  logic [31:0] memory_write_value;
  logic        memory_write_enable;
  logic [31:0] memory_read_value;
  logic [17:0] SW;
  logic [17:0] LEDR;
  logic        timer_irq;
  logic        bus_error;

  memory_responder dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .memory_address      (memory_address),
    .memory_write_value  (memory_write_value),
    .memory_write_enable (memory_write_enable),
    .memory_read_value   (memory_read_value),
    .SW                  (SW),
    .LEDR                (LEDR),
    .timer_irq           (timer_irq),
    .bus_error           (bus_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] rd;
    logic [17:0] led;
    logic        irq;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  // Reference model of the architectural state.
  logic [31:0] m_ram [256];
  logic [17:0] m_led;
  logic [17:0] m_sw_hist1;
  logic [17:0] m_sw_hist2;
  logic [31:0] m_cycle;
  logic [31:0] m_compare;
  logic [1:0]  m_status;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act === want) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, want);
  endtask

  task automatic m_reset();
    m_led = 18'd0; m_sw_hist1 = 18'd0; m_sw_hist2 = 18'd0;
    m_cycle = 32'd0; m_compare = 32'hFFFF_FFFF; m_status = 2'b00;
  endtask

  function automatic logic is_io_reg(input logic [31:0] a);
    return (a[15:0] == 16'h0) || (a[15:0] == 16'h4) || (a[15:0] == 16'h8) ||
           (a[15:0] == 16'hC) || (a[15:0] == 16'h10);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a % 32'd4 != 32'd0) return 32'd0;
    if (a[31:16] == 16'hFFFF) begin
      case (a[15:0])
        16'h0000: return {14'd0, m_led};
        16'h0004: return {14'd0, m_sw_hist2};
        16'h0008: return m_cycle;
        16'h000C: return m_compare;
        16'h0010: return {30'd0, m_status};
        default:  return 32'd0;
      endcase
    end
    if (a < 32'd1024) return m_ram[a[9:2]];
    return 32'd0;
  endfunction

  task automatic m_edge(input logic [31:0] a, input logic [31:0] d, input logic w);
    logic io, ram, legal, match, cyc_wr;
    logic [1:0] clr;
    io     = (a % 32'd4 == 32'd0) && (a[31:16] == 16'hFFFF);
    ram    = (a % 32'd4 == 32'd0) && !io && (a < 32'd1024);
    legal  = ram || (io && is_io_reg(a));
    match  = (m_cycle == m_compare);
    clr    = 2'b00;
    cyc_wr = 1'b0;
    if (w && legal) begin
      if (ram) m_ram[a[9:2]] = d;
      else if (a[15:0] == 16'h0000) m_led = d[17:0];
      else if (a[15:0] == 16'h0008) cyc_wr = 1'b1;
      else if (a[15:0] == 16'h000C) m_compare = d;
      else if (a[15:0] == 16'h0010) clr = d[1:0];
    end
    m_cycle    = cyc_wr ? d : m_cycle + 32'd1;
    m_status   = (m_status & ~clr) | {w && !legal, match};
    m_sw_hist2 = m_sw_hist1;
    m_sw_hist1 = SW;
  endtask

  // One bus cycle: expected outputs go to the scoreboard, model advances at the edge.
  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic w);
    exp_t e;
    memory_address      = a;
    memory_write_value  = d;
    memory_write_enable = w;
    e.rd  = m_read(a);
    e.led = m_led;
    e.irq = m_status[0];
    e.err = m_status[1];
    exp_q.push_back(e);
    @(posedge clock);
    if (reset_n) m_edge(a, d, w);
    #1;
  endtask

  // Monitor: compare DUT outputs mid-cycle against the oldest expectation.
  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("read@%h", memory_address), memory_read_value, e.rd);
      check("LEDR", {14'd0, LEDR}, {14'd0, e.led});
      check("timer_irq", {31'd0, timer_irq}, {31'd0, e.irq});
      check("bus_error", {31'd0, bus_error}, {31'd0, e.err});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int rise;
    logic [31:0] a;
    reset_n = 1'b0; memory_address = 32'd0; memory_write_value = 32'd0;
    memory_write_enable = 1'b0; SW = 18'd0;
    m_reset();
    repeat (2) @(posedge clock);
    #1;
    memory_address = 32'hFFFF_000C;
    #1;
    check("rst_compare", memory_read_value, 32'hFFFF_FFFF);
    check("rst_LEDR", {14'd0, LEDR}, 32'd0);
    check("rst_irq", {31'd0, timer_irq}, 32'd0);
    check("rst_err", {31'd0, bus_error}, 32'd0);
    reset_n = 1'b1;
    step(32'hFFFF_0008, 32'd0, 1'b0);
    step(32'hFFFF_0008, 32'd0, 1'b0);

    for (int i = 0; i < 256; i++) step(32'(i * 4), $urandom, 1'b1);

    step(32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
    step(32'h0000_0010, 32'd0, 1'b0);
    step(32'h0000_03FC, 32'h1234_5678, 1'b1);
    step(32'h0000_03FC, 32'd0, 1'b0);
    step(32'h0000_0400, 32'd0, 1'b0);

    step(32'hFFFF_0000, 32'h0003_FFFF, 1'b1);
    step(32'hFFFF_0000, 32'd0, 1'b0);
    SW = 18'h155;
    for (int i = 0; i < 4; i++) step(32'hFFFF_0004, 32'd0, 1'b0);
    step(32'hFFFF_0004, 32'hFFFF_FFFF, 1'b1);

    step(32'hFFFF_0008, 32'd1000, 1'b1);
    step(32'hFFFF_000C, 32'd20, 1'b1);
    step(32'hFFFF_0010, 32'd3, 1'b1);
    step(32'hFFFF_0008, 32'd10, 1'b1);
    rise = -1;
    for (int i = 1; i <= 20; i++) begin
      if (timer_irq && rise < 0) rise = i - 1;
      step(32'hFFFF_0010, 32'd0, 1'b0);
    end
    check("irq_rise_delay", 32'(rise), 32'd11);
    step(32'hFFFF_0010, 32'd1, 1'b1);
    step(32'hFFFF_0010, 32'd0, 1'b0);
    step(32'hFFFF_0008, 32'hFFFF_FFFF, 1'b1);
    step(32'hFFFF_0008, 32'd0, 1'b0);
    step(32'hFFFF_0008, 32'd0, 1'b0);

    // Match set coinciding with a W1C of the same bit.
    step(32'hFFFF_0008, 32'd100, 1'b1);
    step(32'hFFFF_000C, 32'd102, 1'b1);
    step(32'hFFFF_0000, 32'd0, 1'b0);
    step(32'hFFFF_0010, 32'd1, 1'b1);
    step(32'hFFFF_0010, 32'd0, 1'b0);

    step(32'h0000_0002, 32'hAAAA_AAAA, 1'b1);
    step(32'h0000_0000, 32'd0, 1'b0);
    step(32'hFFFF_0010, 32'd2, 1'b1);
    step(32'h0000_0800, 32'hBBBB_BBBB, 1'b1);
    step(32'h0000_0000, 32'd0, 1'b0);
    step(32'hFFFF_0020, 32'h0001_2345, 1'b1);
    step(32'hFFFF_0000, 32'd0, 1'b0);
    step(32'hFFFF_0010, 32'd3, 1'b1);
    for (int i = 0; i < 50; i++) begin
      case (i % 3)
        0:       a = 32'h0000_0800;
        1:       a = 32'h0000_0003;
        default: a = 32'hFFFF_0020;
      endcase
      step(a, $urandom, 1'b0);
    end

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) SW = 18'($urandom);
      case ($urandom_range(0, 7))
        0, 1:    a = 32'($urandom_range(0, 255) * 4);
        2:       a = 32'($urandom_range(0, 1023)) | 32'd1;
        3:       a = 32'hFFFF_0000 + 32'($urandom_range(0, 4) * 4);
        4:       a = 32'hFFFF_0000 + 32'($urandom_range(5, 100) * 4);
        5:       a = 32'h0000_0400 + 32'($urandom_range(0, 5000) * 4);
        6:       a = {16'($urandom_range(1, 16'hFFFE)), 14'($urandom), 2'b00};
        default: a = 32'hFFFF_000C;
      endcase
      if (a == 32'hFFFF_000C) step(a, m_cycle + 32'($urandom_range(1, 6)), 1'b1);
      else step(a, $urandom, 1'($urandom_range(0, 1)));
    end

    // Reset asserted part-way through an LED store with status bits set.
    step(32'hFFFF_0000, 32'h0002_AAAA, 1'b1);
    step(32'h0000_0801, 32'd0, 1'b1);
    memory_address = 32'hFFFF_0000; memory_write_value = 32'h0003_FFFF;
    memory_write_enable = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("midrst_LEDR", {14'd0, LEDR}, 32'd0);
    check("midrst_err", {31'd0, bus_error}, 32'd0);
    m_reset();
    @(posedge clock);
    #1;
    memory_write_enable = 1'b0;
    reset_n = 1'b1;
    step(32'hFFFF_0000, 32'd0, 1'b0);
    step(32'hFFFF_0008, 32'd0, 1'b0);
    step(32'h0000_03FC, 32'd0, 1'b0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
